is_uart_tx_fsm: RTL and testbench
=================================

Name: is_uart_tx_fsm

Overview:
UART transmitter and serialiser, the transmit-side counterpart of the controller's receive FSM.
- Accepts bytes over a valid/ready handshake into a one-entry holding register.
- Serialises each byte onto txd_o, one bit per tx_ce_i baud tick: start bit, DATA_BITS LSB-first, optional parity bit, STOP_BITS stop bits.
- Sits inside the UART controller between the host-side data path and the TXD pin register; tx_ce_i comes from the shared baud divider.

Parameters:
DATA_BITS, 8, data bits per frame, legal range 5..8
STOP_BITS, 2, stop bits per frame, legal values 1 or 2
PARITY_MODE, PAR_SPACE, parity type from package enum: PAR_NONE, PAR_EVEN, PAR_ODD, PAR_MARK, PAR_SPACE

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset, asynchronous, active-low
tx_ce_i  in  1  baud-rate tick, one clk_i cycle wide
tx_data_i  in  8  byte to send; only bits [DATA_BITS-1:0] are used
tx_valid_i  in  1  tx_data_i is valid
tx_ready_o  out  1  holding register empty; byte accepted when tx_valid_i && tx_ready_o
txd_o  out  1  serial line, registered, idle high
tx_busy_o  out  1  frame in progress (state != IDLE)
tx_done_o  out  1  one-cycle pulse on the tick that ends the last stop bit
txct_r_o  out  1  line-idle flag: 1 in IDLE, 0 from start bit to end of frame

Behaviour:
- Reset values (asynchronous, take effect mid-frame too): state=IDLE, txd_o=1, tx_ready_o=1, hold_valid=0, tx_busy_o=0, tx_done_o=0, txct_r_o=1, bit counter=0, shift register=0.
- Handshake:
  - tx_ready_o = ~hold_valid, registered-equivalent.
  - Acceptance is allowed in any state, including mid-frame.
  - On accept, hold<=tx_data_i and hold_valid<=1.
  - tx_data_i is ignored when tx_ready_o=0.
- All line transitions occur only on cycles with tx_ce_i=1. Each bit holds for exactly one tick period.
- State machine (enum tx_state_t):
  - IDLE: txd_o=1. On tx_ce_i && hold_valid: txd_o<=0, shift<=hold, hold_valid<=0, parity accumulator initialised, go START. Data accepted in the same cycle as the tick is not started until the next tick.
  - START: on tick, txd_o<=shift[0], shift right, cnt<=0, go DATA.
  - DATA: on tick:
    - if cnt==DATA_BITS-1: txd_o<=parity bit and go PARITY; or, when PARITY_MODE==PAR_NONE, txd_o<=1 and go STOP.
    - otherwise txd_o<=shift[0], shift right, cnt<=cnt+1.
  - PARITY: on tick, txd_o<=1, cnt<=0, go STOP.
  - STOP: on tick:
    - if cnt==STOP_BITS-1: tx_done_o<=1 for one cycle.
      - If hold_valid, start the next frame back-to-back (txd_o<=0, load shift, go START, no idle gap).
      - Otherwise go IDLE with txd_o=1.
    - otherwise cnt<=cnt+1.
- Parity bit:
  - PAR_EVEN: XOR of data bits.
  - PAR_ODD: inverted XOR of data bits.
  - PAR_MARK: 1.
  - PAR_SPACE: 0.
- Frame length is 1+DATA_BITS+(parity?1:0)+STOP_BITS ticks. Default frame is 12 ticks.
- tx_ce_i asserted every clk_i cycle is legal: one bit per cycle.
- Illegal or unreachable state encodings recover to IDLE with txd_o=1.

Decomposition:
- Package is_pkg_uart_controller holds:
  - parity_mode_t enum (PAR_NONE..PAR_SPACE), shared with the receive FSM.
  - tx_state_t enum: IDLE, START, DATA, PARITY, STOP.
  - Constants UART_DATA_W=8 and UART_MAX_STOP=2.
- Single module, no sub-modules. Parity is computed combinationally from the shift-register load value.

Test Plan:
- Default parameters, tick every 16 cycles, send 0xA5 → txd_o per tick is 0,1,0,1,0,0,1,0,1,0,1,1; tx_done_o pulses once at tick 12; txct_r_o returns to 1.
- Send 0x3C immediately followed by 0xFF while the first frame is running → tx_ready_o drops after second accept and rises at the second start bit; the second start bit follows the last stop bit with no idle tick; 24 ticks total.
- PARITY_MODE=PAR_EVEN, then PAR_ODD, send 0x07 → parity bit is 1 for even and 0 for odd; PAR_NONE with STOP_BITS=1 → 10-tick frame.
- tx_valid_i held high with tx_ready_o=0 and tx_data_i changing → no extra accepts; bytes transmitted exactly in accepted order.
- Assert rstn_i low at tick 5 of a frame → txd_o=1 and tx_ready_o=1 immediately; the next byte after release produces a clean 12-tick frame.
- tx_ce_i tied high, send 0x81 → frame completes in 12 clk_i cycles with the correct bit sequence.

Source files
------------

// File: rtl/is_uart_tx_fsm_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | is_pkg_uart_controller : shared UART controller types and helpers  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package is_pkg_uart_controller;

  localparam int UART_DATA_W   = 8;
  localparam int UART_MAX_STOP = 2;

  typedef enum logic [2:0] {
    PAR_NONE  = 3'd0,
    PAR_EVEN  = 3'd1,
    PAR_ODD   = 3'd2,
    PAR_MARK  = 3'd3,
    PAR_SPACE = 3'd4
  } parity_mode_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Parity over the low nbits of data; bits above nbits are ignored.
  function automatic logic parity_bit(parity_mode_t mode,
                                      logic [UART_DATA_W-1:0] data,
                                      int nbits);
    logic x;
    x = 1'b0;
    for (int i = 0; i < UART_DATA_W; i++) begin
      if (i < nbits) x = x ^ data[i];
    end
    case (mode)
      PAR_EVEN: return x;
      PAR_ODD:  return ~x;
      PAR_MARK: return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/is_uart_tx_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | is_uart_tx_fsm : UART transmitter, one-entry hold reg + serialiser |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module is_uart_tx_fsm
  import is_pkg_uart_controller::*;
#(
  parameter int           DATA_BITS   = 8,
  parameter int           STOP_BITS   = 2,
  parameter parity_mode_t PARITY_MODE = PAR_SPACE
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       tx_ce_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       txd_o,
  output logic       tx_busy_o,
  output logic       tx_done_o,
  output logic       txct_r_o
);

  tx_state_t  r_state, w_state_nxt;
  logic [7:0] r_hold;
  logic       r_hold_valid, w_hold_valid_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic [2:0] r_cnt, w_cnt_nxt;
  logic       r_txd, w_txd_nxt;
  logic       r_par, w_par_nxt;
  logic       r_done, w_done_nxt;
  logic       w_load;
  logic       w_accept;
  logic       w_last_data;
  logic       w_last_stop;
  logic       w_load_par;

  assign w_accept    = tx_valid_i & ~r_hold_valid;
  assign w_last_data = (r_cnt == 3'(DATA_BITS - 1));
  assign w_last_stop = (r_cnt == 3'(STOP_BITS - 1));
  assign w_load_par  = parity_bit(PARITY_MODE, r_hold, DATA_BITS);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state      <= IDLE;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_txd        <= 1'b1;
      r_par        <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_hold_valid <= w_hold_valid_nxt;
      r_shift      <= w_shift_nxt;
      r_cnt        <= w_cnt_nxt;
      r_txd        <= w_txd_nxt;
      r_par        <= w_par_nxt;
      r_done       <= w_done_nxt;
      if (w_accept) r_hold <= tx_data_i;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:   if (tx_ce_i && r_hold_valid) w_state_nxt = START;
      START:  if (tx_ce_i) w_state_nxt = DATA;
      DATA:   if (tx_ce_i && w_last_data)
                w_state_nxt = (PARITY_MODE == PAR_NONE) ? STOP : PARITY;
      PARITY: if (tx_ce_i) w_state_nxt = STOP;
      STOP:   if (tx_ce_i && w_last_stop)
                w_state_nxt = r_hold_valid ? START : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_txd_nxt   = r_txd;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_par_nxt   = r_par;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        w_txd_nxt = 1'b1;
        if (tx_ce_i && r_hold_valid) w_load = 1'b1;
      end
      START: if (tx_ce_i) begin
        w_txd_nxt   = r_shift[0];
        w_shift_nxt = {1'b0, r_shift[7:1]};
        w_cnt_nxt   = '0;
      end
      DATA: if (tx_ce_i) begin
        if (w_last_data) begin
          w_txd_nxt = (PARITY_MODE == PAR_NONE) ? 1'b1 : r_par;
          w_cnt_nxt = '0;
        end else begin
          w_txd_nxt   = r_shift[0];
          w_shift_nxt = {1'b0, r_shift[7:1]};
          w_cnt_nxt   = r_cnt + 3'd1;
        end
      end
      PARITY: if (tx_ce_i) begin
        w_txd_nxt = 1'b1;
        w_cnt_nxt = '0;
      end
      STOP: if (tx_ce_i) begin
        if (w_last_stop) begin
          w_done_nxt = 1'b1;
          w_txd_nxt  = 1'b1;
          // A byte already waiting starts on this same tick: no idle gap.
          if (r_hold_valid) w_load = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 3'd1;
        end
      end
      default: begin
        w_txd_nxt = 1'b1;
        w_cnt_nxt = '0;
      end
    endcase
    if (w_load) begin
      w_txd_nxt   = 1'b0;
      w_shift_nxt = r_hold;
      w_par_nxt   = w_load_par;
    end
    w_hold_valid_nxt = w_accept ? 1'b1 : (w_load ? 1'b0 : r_hold_valid);
  end

  assign tx_ready_o = ~r_hold_valid;
  assign txd_o      = r_txd;
  assign tx_busy_o  = (r_state != IDLE);
  assign txct_r_o   = (r_state == IDLE);
  assign tx_done_o  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_is_uart_tx_fsm.sv
`default_nettype none
// Bench for is_uart_tx_fsm: five parameter lanes, each checked every cycle
// against a frame-level model that expands accepted bytes into a bit queue.
module tb_is_uart_tx_fsm;
  import is_pkg_uart_controller::*;

  localparam int NL = 5;

  logic          clk;
  logic          rstn;
  logic          ce;
  logic [NL-1:0] valid;
  logic [NL-1:0] ready, txd, busy, done, txct;
  logic [7:0]    data [NL];

  int n_checks = 0;
  int n_pass   = 0;
  int ce_per   = 16;
  int ce_cnt   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  // Baud tick: one cycle wide, every ce_per cycles (ce_per=1 ties it high).
  initial begin
    ce = 1'b0;
    forever begin
      @(negedge clk);
      ce_cnt++;
      if (ce_cnt >= ce_per) begin
        ce     = 1'b1;
        ce_cnt = 0;
      end else begin
        ce = 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NL; g++) begin : g_lane
    localparam int DB = (g == 4) ? 5 : 8;
    localparam int SB = (g >= 3) ? 1 : 2;
    localparam parity_mode_t PM = (g == 1) ? PAR_EVEN :
                                  (g == 2) ? PAR_ODD  :
                                  (g == 3) ? PAR_NONE :
                                  (g == 4) ? PAR_MARK : PAR_SPACE;

    is_uart_tx_fsm #(
      .DATA_BITS   (DB),
      .STOP_BITS   (SB),
      .PARITY_MODE (PM)
    ) u_dut (
      .clk_i      (clk),
      .rstn_i     (rstn),
      .tx_ce_i    (ce),
      .tx_data_i  (data[g]),
      .tx_valid_i (valid[g]),
      .tx_ready_o (ready[g]),
      .txd_o      (txd[g]),
      .tx_busy_o  (busy[g]),
      .tx_done_o  (done[g]),
      .txct_r_o   (txct[g])
    );

    bit       m_hold_v, m_active, m_line, m_done;
    bit [7:0] m_hold;
    bit       m_bits[$];

    function automatic bit par_of(bit [7:0] d);
      int ones;
      ones = $countones(d & 8'((1 << DB) - 1));
      case (PM)
        PAR_EVEN: return bit'(ones % 2);
        PAR_ODD:  return bit'(1 - ones % 2);
        PAR_MARK: return 1'b1;
        default:  return 1'b0;
      endcase
    endfunction

    // Line drops to the start bit now; remaining bits wait in the queue.
    task automatic start_frame();
      m_bits.delete();
      for (int i = 0; i < DB; i++) m_bits.push_back(m_hold[i]);
      if (PM != PAR_NONE) m_bits.push_back(par_of(m_hold));
      for (int i = 0; i < SB; i++) m_bits.push_back(1'b1);
      m_line   = 1'b0;
      m_active = 1'b1;
      m_hold_v = 1'b0;
    endtask

    task automatic model_reset();
      m_hold_v = 1'b0;
      m_active = 1'b0;
      m_line   = 1'b1;
      m_done   = 1'b0;
      m_bits.delete();
    endtask

    task automatic compare();
      check($sformatf("L%0d txd", g),   txd[g],   m_line);
      check($sformatf("L%0d ready", g), ready[g], !m_hold_v);
      check($sformatf("L%0d busy", g),  busy[g],  m_active);
      check($sformatf("L%0d txct", g),  txct[g],  !m_active);
      check($sformatf("L%0d done", g),  done[g],  m_done);
    endtask

    always @(negedge rstn) begin
      model_reset();
      #1;
      compare();
    end

    always @(posedge clk) begin
      bit acc;
      if (!rstn) begin
        model_reset();
      end else begin
        acc    = valid[g] && !m_hold_v;
        m_done = 1'b0;
        if (ce) begin
          if (m_active) begin
            if (m_bits.size() > 0) begin
              m_line = m_bits.pop_front();
            end else begin
              m_done   = 1'b1;
              m_active = 1'b0;
              m_line   = 1'b1;
            end
          end
          if (!m_active && m_hold_v) start_frame();
        end
        if (acc) begin
          m_hold   = data[g];
          m_hold_v = 1'b1;
        end
      end
      #1;
      compare();
    end
  end

  // Offer byte b on every lane; each lane drops valid once its accept edge passes.
  task automatic send_all(input logic [7:0] b);
    logic [NL-1:0] pend, acc;
    int n;
    @(negedge clk);
    pend = '1;
    for (int k = 0; k < NL; k++) data[k] = b;
    valid = pend;
    n = 0;
    while (pend != '0 && n < 2000) begin
      acc = pend & ready;
      @(negedge clk);
      n++;
      pend  = pend & ~acc;
      valid = pend;
    end
    check("send accept", int'(pend), 0);
    valid = '0;
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!ce && n < 200);
    if (!ce) check("tick timeout", ce, 1);
  endtask

  task automatic capture_seq(output logic [11:0] s);
    s = '0;
    for (int i = 0; i < 12; i++) begin
      wait_tick();
      #2;
      s[i] = txd[0];
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy != '0 || ready != '1) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("idle busy", int'(busy), 0);
  endtask

  logic [11:0] seq;

  initial begin
    rstn  = 1'b0;
    valid = '0;
    for (int k = 0; k < NL; k++) data[k] = 8'h00;
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    ce_per = 16;
    send_all(8'hA5);
    capture_seq(seq);
    check("A5 frame", seq, 12'b1101_0100_1010);
    wait_idle();

    send_all(8'h3C);
    send_all(8'hFF);
    wait_idle();

    send_all(8'h07);
    wait_idle();

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (i % 500 == 0) ce_per = $urandom_range(1, 6);
      for (int k = 0; k < NL; k++) begin
        valid[k] = ($urandom_range(0, 3) != 0);
        data[k]  = 8'($urandom);
      end
    end
    valid = '0;
    wait_idle();

    ce_per = 1;
    send_all(8'h81);
    capture_seq(seq);
    check("81 frame", seq, 12'b1101_0000_0010);
    wait_idle();

    ce_per = 16;
    send_all(8'hC3);
    for (int t = 0; t < 5; t++) wait_tick();
    @(negedge clk);
    #2 rstn = 1'b0;
    #2;
    check("rst txd", txd[0], 1);
    check("rst ready", int'(ready), (1 << NL) - 1);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    send_all(8'h5A);
    wait_idle();

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
